// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Oversampling UART receiver, configurable frame, valid/ready output
//            with parity/framing/overrun/break status. Define
//            UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 overrun
);

    localparam int c_SCNT_W = $clog2(OVERSAMPLE);
    localparam int c_BCNT_W = $clog2(DATA_BITS + 1);
    localparam int c_MID    = OVERSAMPLE / 2 - 1;
    localparam int c_LAST   = OVERSAMPLE - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP1   = 3'd4,
        S_STOP2   = 3'd5,
        S_WAIT_HI = 3'd6
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_d;
    logic [DIV_W-1:0]     r_div_q;
    logic [DIV_W-1:0]     r_tick_cnt;
    logic [c_SCNT_W-1:0]  r_scnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_BCNT_W-1:0]  r_bcnt;
    logic                 r_pbit;
    logic                 r_owned;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_brk;
    logic                 r_ovr;

    logic w_fall;
    logic w_start;
    logic w_tick;
    logic w_samp_now;
    logic w_bit;
    logic w_bit_end;
    logic w_done;
    logic w_hs;
    logic w_perr;
    logic w_brk;
    logic w_stop2_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    assign w_fall  = r_rx_d & ~r_rx_s;
    assign w_start = (r_state == S_IDLE) && w_fall;

    // Divisor is latched at start so a mid-frame change cannot stretch the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_q    <= '0;
            r_tick_cnt <= '0;
        end else if (w_start) begin
            r_div_q    <= div;
            r_tick_cnt <= div;
        end else if (r_state != S_IDLE) begin
            if (r_tick_cnt == '0) begin
                r_tick_cnt <= r_div_q;
            end else begin
                r_tick_cnt <= r_tick_cnt - 1'b1;
            end
        end
    end

    assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == '0);
    assign w_bit_end = w_tick && (r_scnt == c_SCNT_W'(c_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scnt <= '0;
        end else if (w_start) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            if (r_scnt == c_SCNT_W'(c_LAST)) begin
                r_scnt <= '0;
            end else begin
                r_scnt <= r_scnt + 1'b1;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;

    // The two early samples are held; the third is taken live at the decision tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_maj <= 2'b11;
        end else if (w_tick) begin
            if (r_scnt == c_SCNT_W'(c_MID - 1)) begin
                r_maj[0] <= r_rx_s;
            end
            if (r_scnt == c_SCNT_W'(c_MID)) begin
                r_maj[1] <= r_rx_s;
            end
        end
    end

    assign w_samp_now = w_tick && (r_scnt == c_SCNT_W'(c_MID + 1));
    assign w_bit      = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_rx_s) | (r_maj[1] & r_rx_s);
`else
    assign w_samp_now = w_tick && (r_scnt == c_SCNT_W'(c_MID));
    assign w_bit      = r_rx_s;
`endif

    assign w_done      = (r_state == S_STOP1) && w_samp_now;
    assign w_hs        = r_valid && ready;
    assign w_perr      = (PARITY == 0) ? 1'b0 : ((^r_shift) ^ r_pbit ^ (PARITY == 1));
    assign w_brk       = ~|{r_shift, r_pbit, w_bit};
    assign w_stop2_err = (r_state == S_STOP2) && w_samp_now && !w_bit && r_owned && r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_pbit  <= 1'b0;
            r_owned <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_shift <= '0;
                        r_bcnt  <= '0;
                        r_pbit  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_samp_now && w_bit) begin
                        r_state <= S_IDLE;
                    end else if (w_bit_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_samp_now) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= r_bcnt + 1'b1;
                    end
                    if (w_bit_end && (r_bcnt == c_BCNT_W'(DATA_BITS))) begin
                        r_state <= (PARITY != 0) ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (w_samp_now) begin
                        r_pbit <= w_bit;
                    end
                    if (w_bit_end) begin
                        r_state <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (w_samp_now) begin
                        if (!w_bit) begin
                            r_state <= S_WAIT_HI;
                        end else if (STOP_BITS == 2) begin
                            r_state <= S_STOP2;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_STOP2: begin
                    if (w_samp_now) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_HI: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // r_owned marks that the held word belongs to the frame still in its stop bits.
            if (w_done) begin
                if (r_valid && !ready) begin
                    r_ovr   <= 1'b1;
                    r_owned <= 1'b0;
                end else begin
                    r_data  <= r_shift;
                    r_perr  <= w_perr;
                    r_ferr  <= !w_bit;
                    r_brk   <= w_brk;
                    r_valid <= 1'b1;
                    r_owned <= 1'b1;
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end else if (w_stop2_err) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign brk        = r_brk;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire
